// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU: control-unit opcodes, R-type funct
// codes, internal ALU control codes and the opcode/funct decoder.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_OP_ADD   = 4'b0000,
    ALU_OP_SUB   = 4'b0001,
    ALU_OP_RTYPE = 4'b0010,
    ALU_OP_AND   = 4'b0011,
    ALU_OP_OR    = 4'b0100,
    ALU_OP_SLT   = 4'b0101,
    ALU_OP_XOR   = 4'b0110,
    ALU_OP_LUI   = 4'b0111
  } alu_op_e;

  typedef enum logic [5:0] {
    FUNCT_SLL  = 6'b000000,
    FUNCT_SRL  = 6'b000010,
    FUNCT_SRA  = 6'b000011,
    FUNCT_ADD  = 6'b100000,
    FUNCT_ADDU = 6'b100001,
    FUNCT_SUB  = 6'b100010,
    FUNCT_SUBU = 6'b100011,
    FUNCT_AND  = 6'b100100,
    FUNCT_OR   = 6'b100101,
    FUNCT_XOR  = 6'b100110,
    FUNCT_NOR  = 6'b100111,
    FUNCT_SLT  = 6'b101010
  } funct_e;

  typedef enum logic [3:0] {
    CTRL_AND = 4'b0000,
    CTRL_OR  = 4'b0001,
    CTRL_ADD = 4'b0010,
    CTRL_XOR = 4'b0011,
    CTRL_SLL = 4'b0100,
    CTRL_SRL = 4'b0101,
    CTRL_SUB = 4'b0110,
    CTRL_SLT = 4'b0111,
    CTRL_SRA = 4'b1000,
    CTRL_LUI = 4'b1001,
    CTRL_NOR = 4'b1100
  } alu_ctrl_e;

  // Anything not recognised, at either level, falls back to ADD.
  function automatic alu_ctrl_e decode_ctrl(input logic [3:0] op, input logic [5:0] fn);
    alu_ctrl_e ctrl;
    ctrl = CTRL_ADD;
    case (op)
      ALU_OP_SUB: ctrl = CTRL_SUB;
      ALU_OP_AND: ctrl = CTRL_AND;
      ALU_OP_OR:  ctrl = CTRL_OR;
      ALU_OP_SLT: ctrl = CTRL_SLT;
      ALU_OP_XOR: ctrl = CTRL_XOR;
      ALU_OP_LUI: ctrl = CTRL_LUI;
      ALU_OP_RTYPE: begin
        case (fn)
          FUNCT_ADD, FUNCT_ADDU: ctrl = CTRL_ADD;
          FUNCT_SUB, FUNCT_SUBU: ctrl = CTRL_SUB;
          FUNCT_AND:             ctrl = CTRL_AND;
          FUNCT_OR:              ctrl = CTRL_OR;
          FUNCT_XOR:             ctrl = CTRL_XOR;
          FUNCT_NOR:             ctrl = CTRL_NOR;
          FUNCT_SLT:             ctrl = CTRL_SLT;
          FUNCT_SLL:             ctrl = CTRL_SLL;
          FUNCT_SRL:             ctrl = CTRL_SRL;
          FUNCT_SRA:             ctrl = CTRL_SRA;
          default:               ctrl = CTRL_ADD;
        endcase
      end
      default: ctrl = CTRL_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_execute_unit_adder32.sv
// Plain combinational adder with carry-in; shared by the ALU add/sub path
// and the branch-target computation.
module adder32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b + {{(WIDTH-1){1'b0}}, carry_in};

endmodule

// File: rtl/alu_execute_unit.sv
// EX-stage compute block: ALU-control decode, 32-bit ALU and branch-target
// adder, with all results registered for the EX/MEM boundary.
module alu_execute_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic [WIDTH-1:0]   pc_plus,
  input  logic [WIDTH-1:0]   offset,
  output logic [3:0]         alu_ctrl,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic [WIDTH-1:0]   branch_target
);

  alu_ctrl_e        alu_ctrl_d;
  logic [3:0]       alu_ctrl_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             overflow_d, overflow_q;
  logic [WIDTH-1:0] branch_target_d, branch_target_q;

  logic             is_sub;
  logic [WIDTH-1:0] addsub_b;
  logic [WIDTH-1:0] addsub_sum;
  logic             slt_bit;

  assign alu_ctrl_d = decode_ctrl(alu_op, funct);
  assign is_sub     = (alu_ctrl_d == CTRL_SUB);
  assign addsub_b   = is_sub ? ~operand_b : operand_b;
  assign slt_bit    = $signed(operand_a) < $signed(operand_b);

  // SUB reuses the same adder as a + ~b + 1.
  adder32 #(.WIDTH(WIDTH)) u_alu_adder (
    .a        (operand_a),
    .b        (addsub_b),
    .carry_in (is_sub),
    .sum      (addsub_sum)
  );

  adder32 #(.WIDTH(WIDTH)) u_branch_adder (
    .a        (pc_plus),
    .b        (offset),
    .carry_in (1'b0),
    .sum      (branch_target_d)
  );

  always_comb begin
    result_d   = addsub_sum;
    overflow_d = 1'b0;
    case (alu_ctrl_d)
      CTRL_AND: result_d = operand_a & operand_b;
      CTRL_OR:  result_d = operand_a | operand_b;
      CTRL_XOR: result_d = operand_a ^ operand_b;
      CTRL_NOR: result_d = ~(operand_a | operand_b);
      CTRL_SLL: result_d = operand_b << shamt;
      CTRL_SRL: result_d = operand_b >> shamt;
      CTRL_SRA: result_d = $signed(operand_b) >>> shamt;
      CTRL_SLT: result_d = {{(WIDTH-1){1'b0}}, slt_bit};
      CTRL_LUI: result_d = operand_b << 16;
      CTRL_ADD: begin
        result_d   = addsub_sum;
        overflow_d = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                     (addsub_sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      CTRL_SUB: begin
        result_d   = addsub_sum;
        overflow_d = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                     (addsub_sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      default: result_d = addsub_sum;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_ctrl_q      <= 4'b0000;
      result_q        <= '0;
      zero_q          <= 1'b0;
      overflow_q      <= 1'b0;
      branch_target_q <= '0;
    end else begin
      alu_ctrl_q      <= alu_ctrl_d;
      result_q        <= result_d;
      zero_q          <= zero_d;
      overflow_q      <= overflow_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign alu_ctrl      = alu_ctrl_q;
  assign result        = result_q;
  assign zero          = zero_q;
  assign overflow      = overflow_q;
  assign branch_target = branch_target_q;

endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed, table-driven bench for alu_execute_unit with hand-computed
// expectations, plus reset sequences at start and mid-stream.
module tb_alu_execute_unit;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] off;
    logic [3:0]  exp_ctrl;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_ovf;
    logic [31:0] exp_bt;
  } vec_t;

  localparam int NUM_VECS = 22;

  logic        clock;
  logic        reset;
  logic [3:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] pc_plus;
  logic [31:0] offset;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [31:0] branch_target;

  int   checks;
  int   failures;
  vec_t vecs [NUM_VECS];

  alu_execute_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock         (clock),
    .reset         (reset),
    .alu_op        (alu_op),
    .funct         (funct),
    .shamt         (shamt),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .pc_plus       (pc_plus),
    .offset        (offset),
    .alu_ctrl      (alu_ctrl),
    .result        (result),
    .zero          (zero),
    .overflow      (overflow),
    .branch_target (branch_target)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply_stimulus(input vec_t v);
    alu_op    = v.alu_op;
    funct     = v.funct;
    shamt     = v.shamt;
    operand_a = v.a;
    operand_b = v.b;
    pc_plus   = v.pc;
    offset    = v.off;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check_output({tag, ".alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, v.exp_ctrl});
    check_output({tag, ".result"}, result, v.exp_result);
    check_output({tag, ".zero"}, {31'd0, zero}, {31'd0, v.exp_zero});
    check_output({tag, ".overflow"}, {31'd0, overflow}, {31'd0, v.exp_ovf});
    check_output({tag, ".branch_target"}, branch_target, v.exp_bt);
  endtask

  task automatic check_cleared(input string tag);
    check_output({tag, ".alu_ctrl"}, {28'd0, alu_ctrl}, 32'd0);
    check_output({tag, ".result"}, result, 32'd0);
    check_output({tag, ".zero"}, {31'd0, zero}, 32'd0);
    check_output({tag, ".overflow"}, {31'd0, overflow}, 32'd0);
    check_output({tag, ".branch_target"}, branch_target, 32'd0);
  endtask

  initial begin
    vec_t v;
    checks   = 0;
    failures = 0;

    //                op       funct      sh     a             b             pc            off           ctrl     result        z     o     bt
    vecs[0]  = '{4'b0000, 6'b000000, 5'd0,  32'd5,        32'd7,        32'h00000100, 32'h00000020, 4'b0010, 32'd12,       1'b0, 1'b0, 32'h00000120};
    vecs[1]  = '{4'b0010, 6'b100010, 5'd0,  32'd9,        32'd9,        32'h00000004, 32'hFFFFFFFC, 4'b0110, 32'd0,        1'b1, 1'b0, 32'h00000000};
    vecs[2]  = '{4'b0001, 6'b000000, 5'd0,  32'd3,        32'd5,        32'h00400000, 32'h00000010, 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h00400010};
    vecs[3]  = '{4'b0000, 6'b000000, 5'd0,  32'h7FFFFFFF, 32'd1,        32'h00400004, 32'h00000008, 4'b0010, 32'h80000000, 1'b0, 1'b1, 32'h0040000C};
    vecs[4]  = '{4'b0001, 6'b000000, 5'd0,  32'h80000000, 32'd1,        32'h00000010, 32'h00000010, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1, 32'h00000020};
    vecs[5]  = '{4'b0011, 6'b000000, 5'd0,  32'h80000000, 32'd1,        32'hFFFFFFFC, 32'h00000008, 4'b0000, 32'd0,        1'b1, 1'b0, 32'h00000004};
    vecs[6]  = '{4'b0010, 6'b000000, 5'd4,  32'h0000FFFF, 32'd1,        32'h00001000, 32'h00000000, 4'b0100, 32'd16,       1'b0, 1'b0, 32'h00001000};
    vecs[7]  = '{4'b0010, 6'b000011, 5'd31, 32'd0,        32'h80000000, 32'h00000000, 32'h00000000, 4'b1000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000};
    vecs[8]  = '{4'b0010, 6'b000010, 5'd31, 32'd0,        32'h80000000, 32'h12345678, 32'h00000008, 4'b0101, 32'd1,        1'b0, 1'b0, 32'h12345680};
    vecs[9]  = '{4'b0101, 6'b000000, 5'd0,  32'hFFFFFFFF, 32'd1,        32'h00000100, 32'hFFFFFF00, 4'b0111, 32'd1,        1'b0, 1'b0, 32'h00000000};
    vecs[10] = '{4'b0010, 6'b101010, 5'd0,  32'd1,        32'hFFFFFFFF, 32'h00000200, 32'h00000004, 4'b0111, 32'd0,        1'b1, 1'b0, 32'h00000204};
    vecs[11] = '{4'b0010, 6'b111111, 5'd0,  32'd10,       32'd20,       32'h00000300, 32'h00000100, 4'b0010, 32'd30,       1'b0, 1'b0, 32'h00000400};
    vecs[12] = '{4'b0010, 6'b100111, 5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000008, 32'h00000008, 4'b1100, 32'd0,        1'b1, 1'b0, 32'h00000010};
    vecs[13] = '{4'b0111, 6'b000000, 5'd0,  32'hDEADBEEF, 32'h00001234, 32'h00000040, 32'h00000004, 4'b1001, 32'h12340000, 1'b0, 1'b0, 32'h00000044};
    vecs[14] = '{4'b0110, 6'b000000, 5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 32'h00000000, 4'b0011, 32'h0FF00FF0, 1'b0, 1'b0, 32'h00000000};
    vecs[15] = '{4'b0100, 6'b000000, 5'd0,  32'h0000000F, 32'h000000F0, 32'h80000000, 32'h80000000, 4'b0001, 32'h000000FF, 1'b0, 1'b0, 32'h00000000};
    vecs[16] = '{4'b1111, 6'b100010, 5'd0,  32'd1,        32'd2,        32'h00000010, 32'h00000001, 4'b0010, 32'd3,        1'b0, 1'b0, 32'h00000011};
    vecs[17] = '{4'b0010, 6'b100001, 5'd0,  32'hFFFFFFFF, 32'd1,        32'h00000020, 32'h00000020, 4'b0010, 32'd0,        1'b1, 1'b0, 32'h00000040};
    vecs[18] = '{4'b0010, 6'b100100, 5'd0,  32'h000000FF, 32'h0000000F, 32'h00000030, 32'h00000000, 4'b0000, 32'h0000000F, 1'b0, 1'b0, 32'h00000030};
    vecs[19] = '{4'b0010, 6'b100110, 5'd0,  32'd5,        32'd3,        32'h00000030, 32'h00000004, 4'b0011, 32'd6,        1'b0, 1'b0, 32'h00000034};
    vecs[20] = '{4'b0010, 6'b100011, 5'd0,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000050, 32'h00000010, 4'b0110, 32'h80000000, 1'b0, 1'b1, 32'h00000060};
    vecs[21] = '{4'b0010, 6'b100101, 5'd0,  32'd1,        32'd2,        32'h00000060, 32'h00000008, 4'b0001, 32'd3,        1'b0, 1'b0, 32'h00000068};

    // Reset held two cycles with non-trivial inputs on every port.
    reset = 1'b1;
    apply_stimulus(vecs[3]);
    repeat (2) @(posedge clock);
    #1;
    check_cleared("reset_start");

    // Vectors issued back to back: each result must appear exactly one edge later.
    reset = 1'b0;
    for (int i = 0; i < NUM_VECS; i++) begin
      apply_stimulus(vecs[i]);
      @(posedge clock);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset arriving alongside an ADD must suppress it.
    reset = 1'b1;
    apply_stimulus(vecs[0]);
    @(posedge clock);
    #1;
    check_cleared("reset_mid");

    reset = 1'b0;
    v = vecs[2];
    apply_stimulus(v);
    @(posedge clock);
    #1;
    check_all("after_reset", v);

    // Holding inputs steady keeps the registered outputs steady.
    @(posedge clock);
    #1;
    check_all("hold", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

endmodule
